// File: rtl/rom_arb_pkg.sv
// Shared constants and payload types for the instruction-ROM port arbiter.
// Port indices, priority-mode encodings and the response-slot record.
package rom_arb_pkg;

  localparam int unsigned PORT_IFETCH = 0;
  localparam int unsigned PORT_DATA   = 1;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  localparam int unsigned RSP_DATA_W = 32;

  // One registered response per port.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } rsp_slot_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request combinational arbiter, round-robin or fixed priority.
// Ports:
//   req[1:0]   - eligible requests
//   mode       - PRIO_RR or PRIO_FIXED (port 0 always wins)
//   last_grant - index of the most recent winner
//   grant[1:0] - one-hot grant, zero when nothing is requested
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       mode,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the port that did not win last
  // time gets it, unless fixed mode pins the win to port 0.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (mode == PRIO_FIXED || last_grant) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single combinational instruction-ROM read port between the
// fetch port (0) and the data/debug port (1), one registered response each.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   pN_req_valid/addr/ready    - request handshake; ready is combinational
//   pN_rsp_valid/data/err      - held response, err for out-of-range address
//   pN_rsp_ready               - requester consumes the held response
//   rom_a, rom_spo             - ROM address out, ROM data in (same cycle)
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned MEM_SIZE      = 128,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  output logic                  p0_req_ready,
  output logic                  p0_rsp_valid,
  output logic [RSP_DATA_W-1:0] p0_rsp_data,
  output logic                  p0_rsp_err,
  input  logic                  p0_rsp_ready,
  input  logic                  p1_req_valid,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_req_ready,
  output logic                  p1_rsp_valid,
  output logic [RSP_DATA_W-1:0] p1_rsp_data,
  output logic                  p1_rsp_err,
  input  logic                  p1_rsp_ready,
  output logic [ADDR_WIDTH-1:0] rom_a,
  input  logic [RSP_DATA_W-1:0] rom_spo
);

  localparam logic MODE = (PRIORITY_MODE != 0) ? PRIO_FIXED : PRIO_RR;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH never flags an error.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [1:0]            w_req_vld;
  logic [1:0]            w_rsp_rdy;
  logic [1:0]            w_elig;
  logic [1:0]            w_grant;
  logic                  w_oor;
  logic [RSP_DATA_W-1:0] w_cap_data;

  rsp_slot_t [1:0]       r_slot;
  logic                  r_last_grant;

  assign w_req_vld[PORT_IFETCH] = p0_req_valid;
  assign w_req_vld[PORT_DATA]   = p1_req_valid;
  assign w_rsp_rdy[PORT_IFETCH] = p0_rsp_ready;
  assign w_rsp_rdy[PORT_DATA]   = p1_rsp_ready;

  // A slot being drained this cycle counts as free; nothing is eligible in reset.
  always_comb begin
    w_elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = rst_n & w_req_vld[i] & (~r_slot[i].valid | w_rsp_rdy[i]);
    end
  end

  rr_arbiter2 u_arb (
    .req        (w_elig),
    .mode       (MODE),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // ROM follows the winner; idle cycles show the port-0 address.
  assign rom_a      = w_grant[PORT_DATA] ? p1_req_addr : p0_req_addr;
  assign w_oor      = ({1'b0, rom_a} >= MEM_LIMIT);
  assign w_cap_data = w_oor ? '0 : rom_spo;

  // Response slots and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_last_grant <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_slot[i].valid <= 1'b1;
          r_slot[i].err   <= w_oor;
          r_slot[i].data  <= w_cap_data;
        end else if (w_rsp_rdy[i]) begin
          r_slot[i].valid <= 1'b0;
        end
      end
      if (|w_grant) begin
        r_last_grant <= w_grant[PORT_DATA];
      end
    end
  end

  assign p0_req_ready = w_grant[PORT_IFETCH];
  assign p0_rsp_valid = r_slot[PORT_IFETCH].valid;
  assign p0_rsp_data  = r_slot[PORT_IFETCH].data;
  assign p0_rsp_err   = r_slot[PORT_IFETCH].err;

  assign p1_req_ready = w_grant[PORT_DATA];
  assign p1_rsp_valid = r_slot[PORT_DATA].valid;
  assign p1_rsp_data  = r_slot[PORT_DATA].data;
  assign p1_rsp_err   = r_slot[PORT_DATA].err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: three instances share one stimulus stream
//   0: round-robin, MEM_SIZE 128   1: round-robin, MEM_SIZE 100
//   2: fixed priority, MEM_SIZE 128
// Each instance has its own ROM model (word k = 0xA5000000 + k).
module tb_rom_port_arbiter;

  localparam int unsigned AW = 7;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          p0v, p1v, p0rr, p1rr;
  logic [AW-1:0] p0a, p1a;

  logic [NI-1:0] rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0]   rd0 [NI];
  logic [31:0]   rd1 [NI];
  logic [31:0]   spo [NI];
  logic [AW-1:0] ra  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    rom_port_arbiter #(
      .ADDR_WIDTH    (AW),
      .MEM_SIZE      ((k == 1) ? 100 : 128),
      .PRIORITY_MODE ((k == 2) ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p0_req_valid (p0v),
      .p0_req_addr  (p0a),
      .p0_req_ready (rdy0[k]),
      .p0_rsp_valid (rv0[k]),
      .p0_rsp_data  (rd0[k]),
      .p0_rsp_err   (re0[k]),
      .p0_rsp_ready (p0rr),
      .p1_req_valid (p1v),
      .p1_req_addr  (p1a),
      .p1_req_ready (rdy1[k]),
      .p1_rsp_valid (rv1[k]),
      .p1_rsp_data  (rd1[k]),
      .p1_rsp_err   (re1[k]),
      .p1_rsp_ready (p1rr),
      .rom_a        (ra[k]),
      .rom_spo      (spo[k])
    );
    assign spo[k] = 32'hA500_0000 + 32'(ra[k]);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, per port slot contents plus last winner.
  int          ms [NI] = '{128, 100, 128};
  int          pm [NI] = '{0, 0, 1};
  bit          mv [NI][2];
  bit          me [NI][2];
  logic [31:0] md [NI][2];
  int          mlast [NI];
  int          mg [NI];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mlast[k] = 1;
      mg[k]    = -1;
      for (int i = 0; i < 2; i++) begin
        mv[k][i] = 1'b0;
        me[k][i] = 1'b0;
        md[k][i] = 32'h0;
      end
    end
  endtask

  // Who wins this cycle, from the arbitration rules.
  task automatic predict();
    bit req_v [2];
    bit rsp_r [2];
    bit el [2];
    req_v[0] = p0v; req_v[1] = p1v;
    rsp_r[0] = p0rr; rsp_r[1] = p1rr;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 2; i++) el[i] = rst_n && req_v[i] && (!mv[k][i] || rsp_r[i]);
      if (el[0] && el[1])      mg[k] = (pm[k] == 1) ? 0 : 1 - mlast[k];
      else if (el[0])          mg[k] = 0;
      else if (el[1])          mg[k] = 1;
      else                     mg[k] = -1;
    end
  endtask

  task automatic commit();
    bit rsp_r [2];
    int addr;
    rsp_r[0] = p0rr; rsp_r[1] = p1rr;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (mg[k] == i) begin
          addr     = (i == 1) ? int'(p1a) : int'(p0a);
          mv[k][i] = 1'b1;
          me[k][i] = (addr >= ms[k]);
          md[k][i] = me[k][i] ? 32'h0 : 32'hA500_0000 + 32'(addr);
        end else if (rsp_r[i]) begin
          mv[k][i] = 1'b0;
        end
      end
      if (mg[k] >= 0) mlast[k] = mg[k];
    end
  endtask

  task automatic check_comb();
    for (int k = 0; k < NI; k++) begin
      chk("req_ready0", k, 32'(rdy0[k]), 32'(mg[k] == 0));
      chk("req_ready1", k, 32'(rdy1[k]), 32'(mg[k] == 1));
      chk("rom_a", k, 32'(ra[k]), (mg[k] == 1) ? 32'(p1a) : 32'(p0a));
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < NI; k++) begin
      chk("rsp_valid0", k, 32'(rv0[k]), 32'(mv[k][0]));
      chk("rsp_err0",   k, 32'(re0[k]), 32'(me[k][0]));
      chk("rsp_data0",  k, rd0[k], md[k][0]);
      chk("rsp_valid1", k, 32'(rv1[k]), 32'(mv[k][1]));
      chk("rsp_err1",   k, 32'(re1[k]), 32'(me[k][1]));
      chk("rsp_data1",  k, rd1[k], md[k][1]);
    end
  endtask

  task automatic drive(input bit v0, input int a0, input bit r0, input bit v1, input int a1, input bit r1);
    p0v = v0; p0a = AW'(a0); p0rr = r0;
    p1v = v1; p1a = AW'(a1); p1rr = r1;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic pre_edge();
    #1;
    predict();
    check_comb();
  endtask

  task automatic post_edge();
    @(posedge clk);
    if (rst_n) commit();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit p0v; int a0; bit r0;
    bit p1v; int a1; bit r1;
    bit g0; bit g1;
    bit v0; logic [31:0] d0;
    bit v1; logic [31:0] d1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Expected values for the round-robin instances, starting from reset.
    tbl[0]  = '{1, 1, 1, 1, 2, 1, 1, 0, 1, 32'hA500_0001, 0, 32'h0};
    tbl[1]  = '{1, 1, 1, 1, 2, 1, 0, 1, 0, 32'hA500_0001, 1, 32'hA500_0002};
    tbl[2]  = '{1, 1, 1, 1, 2, 1, 1, 0, 1, 32'hA500_0001, 0, 32'hA500_0002};
    tbl[3]  = '{1, 1, 1, 1, 2, 1, 0, 1, 0, 32'hA500_0001, 1, 32'hA500_0002};
    tbl[4]  = '{1, 7, 1, 1, 2, 0, 1, 0, 1, 32'hA500_0007, 1, 32'hA500_0002};
    tbl[5]  = '{1, 8, 1, 1, 2, 0, 1, 0, 1, 32'hA500_0008, 1, 32'hA500_0002};
    tbl[6]  = '{1, 9, 1, 1, 4, 1, 0, 1, 0, 32'hA500_0008, 1, 32'hA500_0004};
    tbl[7]  = '{1, 5, 1, 0, 4, 1, 1, 0, 1, 32'hA500_0005, 0, 32'hA500_0004};
    tbl[8]  = '{0, 3, 1, 0, 4, 1, 0, 0, 0, 32'hA500_0005, 0, 32'hA500_0004};
    tbl[9]  = '{1, 10, 1, 0, 4, 1, 1, 0, 1, 32'hA500_000A, 0, 32'hA500_0004};
    tbl[10] = '{1, 11, 1, 0, 4, 1, 1, 0, 1, 32'hA500_000B, 0, 32'hA500_0004};
    tbl[11] = '{1, 12, 0, 0, 4, 1, 0, 0, 1, 32'hA500_000B, 0, 32'hA500_0004};
    tbl[12] = '{0, 12, 1, 0, 4, 1, 0, 0, 0, 32'hA500_000B, 0, 32'hA500_0004};

    @(negedge clk);
    do_reset();

    for (int n = 0; n < 13; n++) begin
      drive(tbl[n].p0v, tbl[n].a0, tbl[n].r0, tbl[n].p1v, tbl[n].a1, tbl[n].r1);
      pre_edge();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_g0", n), k, 32'(rdy0[k]), 32'(tbl[n].g0));
        chk($sformatf("tbl%0d_g1", n), k, 32'(rdy1[k]), 32'(tbl[n].g1));
      end
      post_edge();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_v0", n), k, 32'(rv0[k]), 32'(tbl[n].v0));
        chk($sformatf("tbl%0d_d0", n), k, rd0[k], tbl[n].d0);
        chk($sformatf("tbl%0d_v1", n), k, 32'(rv1[k]), 32'(tbl[n].v1));
        chk($sformatf("tbl%0d_d1", n), k, rd1[k], tbl[n].d1);
      end
      @(negedge clk);
    end

    // Out-of-range on the MEM_SIZE=100 instance, then recovery.
    drive(1, 120, 1, 0, 0, 1);
    pre_edge();
    post_edge();
    chk("oor_err", 1, 32'(re0[1]), 32'd1);
    chk("oor_data", 1, rd0[1], 32'h0);
    chk("inrange_128", 0, rd0[0], 32'hA500_0078);
    chk("inrange_128_err", 0, 32'(re0[0]), 32'd0);
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 1);
    pre_edge();
    post_edge();
    chk("oor_clear_err", 1, 32'(re0[1]), 32'd0);
    chk("oor_clear_data", 1, rd0[1], 32'hA500_0003);
    @(negedge clk);

    // Fixed priority: port 0 wins every tie.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(1, 1, 1, 1, 2, 1);
      pre_edge();
      chk("fixed_g0", 2, 32'(rdy0[2]), 32'd1);
      chk("fixed_g1", 2, 32'(rdy1[2]), 32'd0);
      post_edge();
      @(negedge clk);
    end

    // Mid-stream reset with both slots full and held.
    drive(1, 6, 0, 1, 9, 0);
    repeat (2) begin
      pre_edge();
      post_edge();
      @(negedge clk);
    end
    chk("pre_rst_v0", 0, 32'(rv0[0]), 32'd1);
    chk("pre_rst_v1", 0, 32'(rv1[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_v0", k, 32'(rv0[k]), 32'd0);
      chk("rst_v1", k, 32'(rv1[k]), 32'd0);
      chk("rst_rdy0", k, 32'(rdy0[k]), 32'd0);
      chk("rst_rdy1", k, 32'(rdy1[k]), 32'd0);
    end
    model_reset();
    drive(1, 6, 1, 1, 9, 1);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    pre_edge();
    chk("post_rst_tie_g0", 0, 32'(rdy0[0]), 32'd1);
    chk("post_rst_tie_g1", 0, 32'(rdy1[0]), 32'd0);
    post_edge();
    @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), 1'($urandom_range(0, 3) != 0));
      pre_edge();
      post_edge();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
